l2_request_scheduler: RTL and testbench

Sequencing controller that shares the single L2 cache port between the L1 instruction cache, the L1 data cache and an optional prefetch requester. It sits between the L1 caches and the L2 cache. It runs one L2 transaction at a time. It registers the address and write line, and returns the read line through a registered buffer. Arbitration is fixed priority (dcache > icache > prefetch), with a starvation counter that forces an icache grant.

---
 rtl/l2_request_scheduler_pkg.sv | 15 +
 rtl/l2_request_scheduler_if.sv | 56 +++++
 rtl/l2_grant_select.sv | 40 ++++
 rtl/l2_request_scheduler.sv | 114 +++++++++++
 tb/tb_l2_request_scheduler.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l2_request_scheduler_pkg.sv
// Shared LC-3b types for the L2 request scheduler: bus widths, FSM state and owner encodings.
// Imported by the scheduler interface, the grant selector and the scheduler top.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_l1_line;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} l2_sched_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D, OWN_PF} l2_owner_t;

  // Wide enough for the largest legal starvation limit (15).
  localparam int unsigned STARVE_CNT_W = 4;
  typedef logic [STARVE_CNT_W-1:0] starve_cnt_t;

endpackage

// File: rtl/l2_request_scheduler_if.sv
// L1-side and L2-side signals of the L2 request scheduler; pf_* exist only with PREFETCH_PORT_EN.
// master is the scheduler's view, slave is the view of the caches around it.
interface l2_request_scheduler_if;
  import lc3b_types::*;

  logic        icache_read;
  lc3b_word    icache_address;
  lc3b_l1_line icache_rdata;
  logic        icache_resp;

  logic        dcache_read;
  logic        dcache_write;
  lc3b_word    dcache_address;
  lc3b_l1_line dcache_wdata;
  lc3b_l1_line dcache_rdata;
  logic        dcache_resp;

`ifdef PREFETCH_PORT_EN
  logic        pf_read;
  lc3b_word    pf_address;
  lc3b_l1_line pf_rdata;
  logic        pf_resp;
`endif

  lc3b_word    l2cache_address;
  lc3b_l1_line l2cache_wdata;
  lc3b_l1_line l2cache_rdata;
  logic        l2_read;
  logic        l2_write;
  logic        l2_resp;

  modport master (
`ifdef PREFETCH_PORT_EN
    input  pf_read, pf_address,
    output pf_rdata, pf_resp,
`endif
    input  icache_read, icache_address,
    input  dcache_read, dcache_write, dcache_address, dcache_wdata,
    input  l2cache_rdata, l2_resp,
    output icache_rdata, icache_resp, dcache_rdata, dcache_resp,
    output l2cache_address, l2cache_wdata, l2_read, l2_write
  );

  modport slave (
`ifdef PREFETCH_PORT_EN
    output pf_read, pf_address,
    input  pf_rdata, pf_resp,
`endif
    output icache_read, icache_address,
    output dcache_read, dcache_write, dcache_address, dcache_wdata,
    output l2cache_rdata, l2_resp,
    input  icache_rdata, icache_resp, dcache_rdata, dcache_resp,
    input  l2cache_address, l2cache_wdata, l2_read, l2_write
  );

endinterface

// File: rtl/l2_grant_select.sv
// Combinational fixed-priority grant (dcache > icache > prefetch) with forced icache win on starvation.
// Prefetch decode exists only when PREFETCH_PORT_EN is defined.
module l2_grant_select
  import lc3b_types::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        icache_read,
  input  logic        dcache_read,
  input  logic        dcache_write,
`ifdef PREFETCH_PORT_EN
  input  logic        pf_read,
`endif
  input  starve_cnt_t starve_cnt,
  output l2_owner_t   owner,
  output logic        op_write
);

  logic dcache_req;
  logic icache_forced;

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    dcache_req    = dcache_read | dcache_write;
    icache_forced = icache_read && (starve_cnt == starve_cnt_t'(STARVE_LIMIT));
    owner         = OWN_NONE;
    op_write      = 1'b0;
    if (dcache_req && !icache_forced) begin
      owner    = OWN_D;
      op_write = dcache_write;   // read+write together is a write
    end else if (icache_read) begin
      owner = OWN_I;
`ifdef PREFETCH_PORT_EN
    end else if (pf_read) begin
      owner = OWN_PF;
`endif
    end
  end

endmodule

// File: rtl/l2_request_scheduler.sv
// Shares the single L2 port between icache, dcache and (PREFETCH_PORT_EN) a prefetcher,
// one transaction at a time through an IDLE -> ISSUE -> RESP sequence with registered outputs.
module l2_request_scheduler
  import lc3b_types::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  l2_request_scheduler_if.master bus
);

  l2_sched_state_t state;
  l2_owner_t       owner_q;
  l2_owner_t       grant_owner;
  logic            op_write_q;
  logic            grant_write;
  starve_cnt_t     starve_cnt;
  lc3b_l1_line     line_buf;
  lc3b_word        grant_address;

  l2_grant_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant (
    .icache_read  (bus.icache_read),
    .dcache_read  (bus.dcache_read),
    .dcache_write (bus.dcache_write),
`ifdef PREFETCH_PORT_EN
    .pf_read      (bus.pf_read),
`endif
    .starve_cnt   (starve_cnt),
    .owner        (grant_owner),
    .op_write     (grant_write)
  );

  always_comb begin
    case (grant_owner)
      OWN_D:   grant_address = bus.dcache_address;
`ifdef PREFETCH_PORT_EN
      OWN_PF:  grant_address = bus.pf_address;
`endif
      default: grant_address = bus.icache_address;
    endcase
  end

  assign bus.icache_rdata = line_buf;
  assign bus.dcache_rdata = line_buf;
`ifdef PREFETCH_PORT_EN
  assign bus.pf_rdata     = line_buf;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      owner_q             <= OWN_NONE;
      op_write_q          <= 1'b0;
      starve_cnt          <= '0;
      // NOTE: the line buffer is a plain register and is reset so rdata never shows stale lines.
      line_buf            <= '0;
      bus.l2cache_address <= '0;
      bus.l2cache_wdata   <= '0;
      bus.l2_read         <= 1'b0;
      bus.l2_write        <= 1'b0;
      bus.icache_resp     <= 1'b0;
      bus.dcache_resp     <= 1'b0;
`ifdef PREFETCH_PORT_EN
      bus.pf_resp         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_owner != OWN_NONE) begin
            owner_q             <= grant_owner;
            op_write_q          <= grant_write;
            bus.l2cache_address <= grant_address;
            if (grant_write) bus.l2cache_wdata <= bus.dcache_wdata;
            bus.l2_read         <= !grant_write;
            bus.l2_write        <= grant_write;
            if (grant_owner == OWN_I) begin
              starve_cnt <= '0;
            end else if (grant_owner == OWN_D && bus.icache_read &&
                         starve_cnt != starve_cnt_t'(STARVE_LIMIT)) begin
              starve_cnt <= starve_cnt + starve_cnt_t'(1);
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          // The owner gets its pulse even if it dropped the request meanwhile.
          if (bus.l2_resp) begin
            if (!op_write_q) line_buf <= bus.l2cache_rdata;
            bus.l2_read     <= 1'b0;
            bus.l2_write    <= 1'b0;
            bus.icache_resp <= (owner_q == OWN_I);
            bus.dcache_resp <= (owner_q == OWN_D);
`ifdef PREFETCH_PORT_EN
            bus.pf_resp     <= (owner_q == OWN_PF);
`endif
            state <= RESP;
          end
        end
        RESP: begin
          bus.icache_resp <= 1'b0;
          bus.dcache_resp <= 1'b0;
`ifdef PREFETCH_PORT_EN
          bus.pf_resp     <= 1'b0;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_request_scheduler.sv
// Self-checking bench for l2_request_scheduler: table of single transactions with a scoreboard,
// plus hand-written starvation, spurious-l2_resp and mid-transaction reset sequences.
module tb_l2_request_scheduler;
  import lc3b_types::*;

  localparam int unsigned STARVE_LIMIT = 4;
  localparam int          RESP_TIMEOUT = 40;

  typedef struct {
    string        name;
    logic         ireq;
    logic         dread;
    logic         dwrite;
    logic         preq;
    logic [15:0]  iaddr;
    logic [15:0]  daddr;
    logic [15:0]  paddr;
    logic [127:0] wdata;
    logic [127:0] line;
    int           wait_cyc;
    l2_owner_t    exp_owner;
  } vec_t;

  typedef struct {
    l2_owner_t    owner;
    logic [127:0] rdata;
    int           latency;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  vec_t         vecs[$];
  exp_t         sb[$];
  l2_owner_t    owner_q[$];
  logic [127:0] model_line = '0;

  always #5 clk = ~clk;

  l2_request_scheduler_if bus ();

  l2_request_scheduler #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] resp_vec();
`ifdef PREFETCH_PORT_EN
    return {bus.pf_resp, bus.dcache_resp, bus.icache_resp};
`else
    return {1'b0, bus.dcache_resp, bus.icache_resp};
`endif
  endfunction

  function automatic logic [2:0] owner_vec(input l2_owner_t o);
    case (o)
      OWN_I:   return 3'b001;
      OWN_D:   return 3'b010;
      OWN_PF:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic vec_t mk(input string name, input logic i, input logic dr, input logic dw,
                              input logic p, input logic [15:0] ia, input logic [15:0] da,
                              input logic [15:0] pa, input logic [127:0] wd,
                              input logic [127:0] ln, input int w, input l2_owner_t own);
    vec_t v;
    v.name = name;  v.ireq = i;   v.dread = dr;  v.dwrite = dw; v.preq = p;
    v.iaddr = ia;   v.daddr = da; v.paddr = pa;  v.wdata = wd;  v.line = ln;
    v.wait_cyc = w; v.exp_owner = own;
    return v;
  endfunction

  task automatic set_pf(input logic req, input logic [15:0] addr);
`ifdef PREFETCH_PORT_EN
    bus.pf_read    = req;
    bus.pf_address = addr;
`endif
  endtask

  // Drives one vector at a negedge in IDLE, plays the L2 side, and checks the response.
  task automatic run_vec(input vec_t v);
    exp_t        e;
    exp_t        got;
    logic        exp_write;
    logic [15:0] exp_addr;
    logic [1:0]  exp_strobe;
    logic        hold_ok;
    logic [2:0]  rv;
    int          cyc;
    exp_write  = (v.exp_owner == OWN_D) && v.dwrite;
    exp_strobe = exp_write ? 2'b01 : 2'b10;
    case (v.exp_owner)
      OWN_D:   exp_addr = v.daddr;
      OWN_PF:  exp_addr = v.paddr;
      default: exp_addr = v.iaddr;
    endcase
    bus.icache_read    = v.ireq;
    bus.icache_address = v.iaddr;
    bus.dcache_read    = v.dread;
    bus.dcache_write   = v.dwrite;
    bus.dcache_address = v.daddr;
    bus.dcache_wdata   = v.wdata;
    set_pf(v.preq, v.paddr);
    e.owner   = v.exp_owner;
    e.rdata   = exp_write ? model_line : v.line;
    e.latency = v.wait_cyc + 2;
    sb.push_back(e);

    @(negedge clk);
    cyc = 1;
    check({v.name, " strobe"}, 128'({bus.l2_read, bus.l2_write}), 128'(exp_strobe));
    check({v.name, " l2_address"}, 128'(bus.l2cache_address), 128'(exp_addr));
    if (exp_write) check({v.name, " l2_wdata"}, bus.l2cache_wdata, v.wdata);
    hold_ok = 1'b1;
    for (int i = 0; i < v.wait_cyc; i++) begin
      @(negedge clk);
      cyc++;
      if ({bus.l2_read, bus.l2_write} !== exp_strobe || bus.l2cache_address !== exp_addr ||
          resp_vec() != 3'b000) hold_ok = 1'b0;
    end
    if (v.wait_cyc > 0) check({v.name, " held until l2_resp"}, 128'(hold_ok), 128'(1'b1));

    bus.l2cache_rdata = v.line;
    bus.l2_resp       = 1'b1;
    rv = 3'b000;
    while (rv == 3'b000 && cyc < RESP_TIMEOUT) begin
      @(negedge clk);
      cyc++;
      bus.l2_resp = 1'b0;
      rv = resp_vec();
    end
    got = sb.pop_front();
    if (rv == 3'b000) begin
      check({v.name, " resp timeout"}, 128'(rv), 128'(owner_vec(got.owner)));
    end else begin
      check({v.name, " resp owner"}, 128'(rv), 128'(owner_vec(got.owner)));
      check({v.name, " icache_rdata"}, bus.icache_rdata, got.rdata);
      check({v.name, " dcache_rdata"}, bus.dcache_rdata, got.rdata);
`ifdef PREFETCH_PORT_EN
      check({v.name, " pf_rdata"}, bus.pf_rdata, got.rdata);
`endif
      check({v.name, " latency"}, 128'(cyc), 128'(got.latency));
      if (!exp_write) model_line = v.line;
      case (v.exp_owner)
        OWN_I:   bus.icache_read = 1'b0;
        OWN_D:   begin bus.dcache_read = 1'b0; bus.dcache_write = 1'b0; end
        OWN_PF:  set_pf(1'b0, v.paddr);
        default: ;
      endcase
      @(negedge clk);
      check({v.name, " single pulse"}, 128'({resp_vec(), bus.l2_read, bus.l2_write}), '0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n              = 1'b0;
    bus.icache_read    = 1'b0;
    bus.icache_address = '0;
    bus.dcache_read    = 1'b0;
    bus.dcache_write   = 1'b0;
    bus.dcache_address = '0;
    bus.dcache_wdata   = '0;
    bus.l2cache_rdata  = '0;
    bus.l2_resp        = 1'b0;
    set_pf(1'b0, 16'h0);

    vecs.push_back(mk("icache_rd_1230", 1, 0, 0, 0, 16'h1230, 16'h0000, 16'h0000,
                      '0, {16{8'hA5}}, 2, OWN_I));
    vecs.push_back(mk("dcache_wr_4000", 0, 0, 1, 0, 16'h0000, 16'h4000, 16'h0000,
                      {16{8'h11}}, {16{8'hEE}}, 1, OWN_D));
    vecs.push_back(mk("dcache_rd_2222", 0, 1, 0, 0, 16'h0000, 16'h2222, 16'h0000,
                      '0, {4{32'hDEADBEEF}}, 0, OWN_D));
    vecs.push_back(mk("dcache_rd_and_wr", 0, 1, 1, 0, 16'h0000, 16'h3000, 16'h0000,
                      {8{16'h2222}}, {16{8'hCC}}, 0, OWN_D));
    vecs.push_back(mk("d_over_i", 1, 1, 0, 0, 16'h0100, 16'h5000, 16'h0000,
                      '0, {16{8'h5A}}, 1, OWN_D));
    vecs.push_back(mk("i_after_d", 1, 0, 0, 0, 16'h0100, 16'h0000, 16'h0000,
                      '0, {2{64'h0123456789ABCDEF}}, 3, OWN_I));
    vecs.push_back(mk("dcache_wr_keeps_buf", 0, 0, 1, 0, 16'h0000, 16'hFFF0, 16'h0000,
                      {32{4'h9}}, {16{8'h3C}}, 0, OWN_D));
`ifdef PREFETCH_PORT_EN
    vecs.push_back(mk("pf_alone", 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h8888,
                      '0, {16{8'h77}}, 0, OWN_PF));
    vecs.push_back(mk("i_over_pf", 1, 0, 0, 1, 16'h0200, 16'h0000, 16'h9990,
                      '0, {16{8'h42}}, 1, OWN_I));
    vecs.push_back(mk("pf_next", 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h9990,
                      '0, {16{8'h81}}, 0, OWN_PF));
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("reset strobes+resp", 128'({bus.l2_read, bus.l2_write, resp_vec()}), '0);
    check("reset l2_address", 128'(bus.l2cache_address), '0);
    check("reset l2_wdata", bus.l2cache_wdata, '0);
    check("reset rdata", bus.icache_rdata | bus.dcache_rdata, '0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[k]) run_vec(vecs[k]);
    bus.icache_read  = 1'b0;
    bus.dcache_read  = 1'b0;
    bus.dcache_write = 1'b0;
    set_pf(1'b0, 16'h0);
    @(negedge clk);

    // l2_resp while IDLE must be ignored
    bus.l2_resp = 1'b1;
    @(negedge clk);
    bus.l2_resp = 1'b0;
    check("stray l2_resp outputs", 128'({bus.l2_read, bus.l2_write, resp_vec()}), '0);
    @(negedge clk);
    check("stray l2_resp no pulse", 128'(resp_vec()), '0);

    // Starvation: both requesters held, zero-wait L2
    begin
      int got_n;
      int cyc;
      logic [2:0] rv;
      l2_owner_t exp_o;
      for (int k = 0; k < 10; k++)
        owner_q.push_back((k % (STARVE_LIMIT + 1) == STARVE_LIMIT) ? OWN_I : OWN_D);
      bus.icache_read    = 1'b1;
      bus.icache_address = 16'h0C00;
      bus.dcache_read    = 1'b1;
      bus.dcache_address = 16'h0D00;
      bus.l2cache_rdata  = {16{8'hC3}};
      got_n = 0;
      cyc   = 0;
      while (got_n < 10 && cyc < 200) begin
        @(negedge clk);
        cyc++;
        rv = resp_vec();
        if (rv != 3'b000) begin
          exp_o = owner_q.pop_front();
          check($sformatf("starve grant %0d", got_n), 128'(rv), 128'(owner_vec(exp_o)));
          got_n++;
          if (got_n == 10) begin
            bus.icache_read = 1'b0;
            bus.dcache_read = 1'b0;
          end
        end
        bus.l2_resp = bus.l2_read | bus.l2_write;
      end
      check("starve grant count", 128'(got_n), 128'(10));
      bus.l2_resp = 1'b0;
      @(negedge clk);
    end

    // Reset in the middle of ISSUE
    bus.icache_read    = 1'b1;
    bus.icache_address = 16'h0ABC;
    @(negedge clk);
    check("pre-reset l2_read", 128'(bus.l2_read), 128'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    check("async reset l2_read", 128'({bus.l2_read, bus.l2_write}), '0);
    check("async reset l2_address", 128'(bus.l2cache_address), '0);
    check("async reset rdata", bus.icache_rdata, '0);
    model_line = '0;
    @(negedge clk);
    check("no resp across reset", 128'(resp_vec()), '0);
    rst_n = 1'b1;
    run_vec(mk("regrant_after_reset", 1, 0, 0, 0, 16'h0ABC, 16'h0000, 16'h0000,
               '0, {8{16'hBEEF}}, 0, OWN_I));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
